// File: rtl/io_nbit_tile.sv
// WIDTH-bit bidirectional IO tile with per-bit output enable, optional output
// register, input synchroniser and polarity inversion. Optional IO_EDGE_DETECT_EN adds sticky rising-edge flags.
module io_nbit_tile #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [7:0]       FEATURE_ID = 8'd0,
  parameter logic [WIDTH-1:0] OE_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  inout  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] p2f,
  input  logic [WIDTH-1:0] f2p,
  input  logic [31:0]      config_addr,
  input  logic [31:0]      config_data,
  input  logic             config_we,
  input  logic             config_re,
  input  logic [15:0]      tile_id,
  output logic [31:0]      read_data,
  output logic             read_valid
);

  typedef enum logic [7:0] {
    REG_OE   = 8'h00,
    REG_MODE = 8'h01,
    REG_EDGE = 8'h02
  } reg_sel_e;

  logic             hit;
  logic [7:0]       sel;
  logic [WIDTH-1:0] oe_q;
  logic [3:0]       mode_q;
  logic             out_reg, in_sync, in_inv, out_inv;
  logic [WIDTH-1:0] out_val, out_q, drive;
  logic [WIDTH-1:0] raw, sync1_q, sync2_q;
  logic [31:0]      rd_mux;
  logic             unused_cfg;

  assign sel     = config_addr[31:24];
  assign hit     = reset && (config_addr[15:0] == tile_id) && (config_addr[23:16] == FEATURE_ID);
  assign out_reg = mode_q[0];
  assign in_sync = mode_q[1];
  assign in_inv  = mode_q[2];
  assign out_inv = mode_q[3];

  // Only the low WIDTH bits of write data are used.
  assign unused_cfg = ^config_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oe_q   <= OE_RESET;
      mode_q <= '0;
    end else if (hit && config_we) begin
      case (sel)
        REG_OE:   oe_q   <= config_data[WIDTH-1:0];
        REG_MODE: mode_q <= config_data[3:0];
        default:  ;
      endcase
    end
  end

  assign out_val = f2p ^ {WIDTH{out_inv}};
  assign drive   = out_reg ? out_q : out_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_val;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad[i] = oe_q[i] ? drive[i] : 1'bz;
  end

  assign raw = pad ^ {WIDTH{in_inv}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign p2f = in_sync ? sync2_q : raw;

`ifdef IO_EDGE_DETECT_EN
  logic [WIDTH-1:0] prev_q, edge_q, edge_clr;

  assign edge_clr = (hit && config_we && sel == REG_EDGE) ? config_data[WIDTH-1:0] : '0;

  // Set wins over a same-cycle W1C clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= p2f;
      edge_q <= (edge_q & ~edge_clr) | (p2f & ~prev_q);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_OE:   rd_mux[WIDTH-1:0] = oe_q;
      REG_MODE: rd_mux[3:0]       = mode_q;
`ifdef IO_EDGE_DETECT_EN
      REG_EDGE: rd_mux[WIDTH-1:0] = edge_q;
`endif
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else if (hit && config_re) begin
      read_data  <= rd_mux;
      read_valid <= 1'b1;
    end else begin
      read_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_nbit_tile.sv
// Randomised + directed bench for io_nbit_tile against a cycle-history reference model.
module tb_io_nbit_tile;
  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset;
  wire  [W-1:0]  pad;
  logic [W-1:0]  p2f, f2p, ext_val;
  logic [31:0]   config_addr, config_data, read_data;
  logic          config_we, config_re, read_valid;
  logic [15:0]   tile_id;

  // Reference model state
  logic [W-1:0]  m_oe, m_edge, m_out_last, m_p2f_last;
  logic [W-1:0]  raw_hist [2];
  logic [3:0]    m_mode;
  logic [31:0]   m_rd;
  logic          m_rv;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  io_nbit_tile #(.WIDTH(W), .FEATURE_ID(8'd0), .OE_RESET('0)) dut (
    .clk(clk), .reset(reset), .pad(pad), .p2f(p2f), .f2p(f2p),
    .config_addr(config_addr), .config_data(config_data),
    .config_we(config_we), .config_re(config_re), .tile_id(tile_id),
    .read_data(read_data), .read_valid(read_valid)
  );

  // External pad driver: drives every bit the tile is not expected to drive.
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign pad[i] = m_oe[i] ? 1'bz : ext_val[i];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] f_out_val();
    return f2p ^ {W{m_mode[3]}};
  endfunction
  function automatic logic [W-1:0] f_pad();
    logic [W-1:0] drv;
    drv = m_mode[0] ? m_out_last : f_out_val();
    return (m_oe & drv) | (~m_oe & ext_val);
  endfunction
  function automatic logic [W-1:0] f_raw();
    return f_pad() ^ {W{m_mode[2]}};
  endfunction
  function automatic logic [W-1:0] f_p2f();
    return m_mode[1] ? raw_hist[1] : f_raw();
  endfunction
  function automatic logic [31:0] f_reg(input logic [7:0] s);
    logic [31:0] v;
    v = '0;
    if (s == 8'h00) v[W-1:0] = m_oe;
    else if (s == 8'h01) v[3:0] = m_mode;
`ifdef IO_EDGE_DETECT_EN
    else if (s == 8'h02) v[W-1:0] = m_edge;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_oe = '0; m_mode = '0; m_edge = '0; m_out_last = '0; m_p2f_last = '0;
    raw_hist[0] = '0; raw_hist[1] = '0; m_rd = '0; m_rv = 1'b0;
  endtask

  task automatic model_edge();
    logic          hit;
    logic [7:0]    s;
    logic [W-1:0]  cur_p2f, cur_raw, cur_out, clr;
    logic [31:0]   rd_old;
    if (!reset) return;
    s       = config_addr[31:24];
    hit     = (config_addr[15:0] == tile_id) && (config_addr[23:16] == 8'h00);
    cur_p2f = f_p2f();
    cur_raw = f_raw();
    cur_out = f_out_val();
    rd_old  = f_reg(s);
    clr     = '0;
    if (hit && config_we) begin
      if (s == 8'h00) m_oe = config_data[W-1:0];
      else if (s == 8'h01) m_mode = config_data[3:0];
      else if (s == 8'h02) clr = config_data[W-1:0];
    end
`ifdef IO_EDGE_DETECT_EN
    m_edge = (m_edge & ~clr) | (cur_p2f & ~m_p2f_last);
`endif
    if (hit && config_re) begin
      m_rd = rd_old;
      m_rv = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
    raw_hist[1] = raw_hist[0];
    raw_hist[0] = cur_raw;
    m_out_last  = cur_out;
    m_p2f_last  = cur_p2f;
  endtask

  task automatic check_outputs();
    check_val("p2f", 32'(p2f), 32'(f_p2f()));
    check_val("pad", 32'(pad), 32'(f_pad()));
    check_val("read_valid", 32'(read_valid), 32'(m_rv));
    check_val("read_data", read_data, m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    config_we = 1'b0;
    config_re = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cfg(input logic [7:0] s, input logic [31:0] d, input logic we,
                     input logic re, input logic [15:0] id);
    config_addr = {s, 8'h00, id};
    config_data = d;
    config_we   = we;
    config_re   = re;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    f2p = '0; ext_val = '0; config_addr = '0; config_data = '0;
    config_we = 1'b0; config_re = 1'b0; tile_id = 16'h00C3;
    model_reset();
    #3;
    ext_val = 16'hA5A5;
    #1;
    check_val("rst_p2f", 32'(p2f), 32'h0000A5A5);
    check_val("rst_rdata", read_data, 32'h0);
    check_val("rst_rvalid", 32'(read_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // OE mask and tile-id match
    f2p = 16'h1234;
    cfg(8'h00, 32'h000000FF, 1'b1, 1'b0, tile_id);
    check_val("oe_pad_lo", 32'(pad[7:0]), 32'h34);
    check_val("oe_pad_hi", 32'(pad[15:8]), 32'hA5);
    cfg(8'h00, 32'h0000FFFF, 1'b1, 1'b0, tile_id ^ 16'h0001);
    cfg(8'h00, 32'h0, 1'b0, 1'b1, tile_id);
    check_val("oe_keep", read_data, 32'h000000FF);

    // Output register latency, then sync latency
    cfg(8'h00, 32'h0000FFFF, 1'b1, 1'b0, tile_id);
    f2p = '0;
    cfg(8'h01, 32'h1, 1'b1, 1'b0, tile_id);
    f2p = 16'hFFFF;
    #1;
    check_val("oreg_hold", 32'(pad), 32'h0);
    tick();
    check_val("oreg_upd", 32'(pad), 32'h0000FFFF);
    cfg(8'h01, 32'h3, 1'b1, 1'b0, tile_id);
    tick();
    tick();
    f2p = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      tick();
      check_val("sync_lat", 32'(p2f), (k < 3) ? 32'h0000FFFF : 32'h0);
    end

    // Simultaneous write+read returns old value
    cfg(8'h00, 32'h000000FF, 1'b1, 1'b0, tile_id);
    cfg(8'h00, 32'h00000F0F, 1'b1, 1'b1, tile_id);
    check_val("wr_rd_old", read_data, 32'h000000FF);
    check_val("wr_rd_valid", 32'(read_valid), 32'h1);
    tick();
    check_val("valid_pulse", 32'(read_valid), 32'h0);
    cfg(8'h00, 32'h0, 1'b0, 1'b1, tile_id);
    check_val("rd_new", read_data, 32'h00000F0F);

    // Asynchronous reset mid-operation
    cfg(8'h00, 32'h0000FFFF, 1'b1, 1'b0, tile_id);
    cfg(8'h01, 32'hF, 1'b1, 1'b0, tile_id);
    ext_val = 16'h5A3C;
    cfg(8'h01, 32'h0, 1'b0, 1'b1, tile_id);
    check_val("pre_rst_valid", 32'(read_valid), 32'h1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_val("arst_valid", 32'(read_valid), 32'h0);
    check_val("arst_pad", 32'(pad), 32'h00005A3C);
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned s = 0; s < 3; s++) begin
      cfg(8'(s), 32'h0, 1'b0, 1'b1, tile_id);
      check_val("post_rst_reg", read_data, 32'h0);
    end

`ifdef IO_EDGE_DETECT_EN
    ext_val = '0;
    tick();
    cfg(8'h02, 32'h0000FFFF, 1'b1, 1'b0, tile_id);
    ext_val = 16'h0008;
    tick();
    ext_val = '0;
    tick();
    cfg(8'h02, 32'h0, 1'b0, 1'b1, tile_id);
    check_val("edge_set", read_data, 32'h8);
    cfg(8'h02, 32'h8, 1'b1, 1'b0, tile_id);
    cfg(8'h02, 32'h0, 1'b0, 1'b1, tile_id);
    check_val("edge_w1c", read_data, 32'h0);
    ext_val = 16'h0008;
    cfg(8'h02, 32'h8, 1'b1, 1'b0, tile_id);
    ext_val = '0;
    cfg(8'h02, 32'h0, 1'b0, 1'b1, tile_id);
    check_val("edge_set_wins", read_data, 32'h8);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] id;
      f2p     = W'($urandom);
      ext_val = W'($urandom);
      id      = ($urandom_range(0, 7) == 0) ? (tile_id ^ 16'(1 << $urandom_range(0, 15))) : tile_id;
      cfg(8'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), id);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
